ps2_rx_fifo: RTL and testbench

PS/2 keyboard receiver for the FPGC4 I/O path. It deserialises host-bound PS/2 frames from the `ps2c`/`ps2d` pins and buffers the received scan codes in a small FIFO. The MemoryUnit reads the buffered bytes out as a memory-mapped register, and a one-cycle interrupt pulse goes towards the CPU interrupt inputs. It sits between the top-level PS/2 pins and the MemoryUnit, all in the 25 MHz `clk` domain.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_fifo.sv | 53 +++++
 rtl/ps2_rx_fifo.sv | 173 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and PS/2 frame constants for the keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PUSH = 2'd2
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_STOP_IDX   = 10;
  localparam int PS2_PAR_IDX    = 9;

  // Data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_PAR_IDX-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code FIFO: circular buffer with wrapping pointers, occupancy count and
// first-word fall-through head (0x00 while empty).
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     wr,
  input  logic [7:0]               wdata,
  input  logic                     rd,
  output logic [7:0]               q,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_ok;
  logic          wr_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_ok = rd & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok = wr & (~full | rd_ok);
  assign q     = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (rd_ok) rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with scan-code FIFO and push interrupt.
// Optional build macro: PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
//
// state | meaning
// IDLE  | waiting for a start bit (falling bit edge with data low)
// RECV  | shifting data and parity, checking stop bit, timeout armed
// PUSH  | one cycle: write byte to FIFO and pulse irq, or flag overflow
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          ps2c,
  input  logic                          ps2d,
  input  logic                          rd,
  input  logic                          clr,
  output logic [7:0]                    q,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          irq
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]             c_sync;
  logic [1:0]             d_sync;
  logic                   c_filt;
  logic                   c_filt_d;
  logic [FW-1:0]          flt_cnt;
  logic                   bit_edge;
  logic                   bit_val;

  ps2_state_e             state, state_nxt;
  logic [3:0]             bit_cnt, bit_cnt_nxt;
  logic [PS2_PAR_IDX-1:0] shreg, shreg_nxt;
  logic [TW-1:0]          tmr, tmr_nxt;
  logic                   push;
  logic                   ferr_set;
  logic                   par_ok;

  logic                   full;
  logic                   rd_pop;
  logic                   drop;

  // Synchronisers and filter idle high so reset never fakes a bit edge.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      c_sync   <= 2'b11;
      d_sync   <= 2'b11;
      c_filt   <= 1'b1;
      c_filt_d <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      c_sync   <= {c_sync[0], ps2c};
      d_sync   <= {d_sync[0], ps2d};
      c_filt_d <= c_filt;
      if (c_sync[1] == c_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        c_filt  <= c_sync[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= FW'(flt_cnt + 1'b1);
      end
    end
  end

  assign bit_edge = c_filt_d & ~c_filt;
  assign bit_val  = d_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = odd_parity_ok(shreg);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    tmr_nxt     = tmr;
    push        = 1'b0;
    ferr_set    = 1'b0;
    case (state)
      IDLE: begin
        if (bit_edge && !bit_val) begin
          state_nxt   = RECV;
          bit_cnt_nxt = 4'd1;
          tmr_nxt     = TW'(TIMEOUT_CYCLES - 1);
        end
      end
      RECV: begin
        if (bit_edge) begin
          tmr_nxt = TW'(TIMEOUT_CYCLES - 1);
          if (bit_cnt == 4'(PS2_STOP_IDX)) begin
            if (bit_val && par_ok) begin
              state_nxt = PUSH;
            end else begin
              ferr_set  = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            shreg_nxt   = {bit_val, shreg[PS2_PAR_IDX-1:1]};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end else if (tmr == '0) begin
          ferr_set  = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmr_nxt = TW'(tmr - 1'b1);
        end
      end
      PUSH: begin
        push      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tmr     <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      tmr     <= tmr_nxt;
    end
  end

  assign rd_pop = rd & ~empty;
  assign drop   = push & full & ~rd_pop;
  assign irq    = push & (~full | rd_pop);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)     overflow  <= 1'b1;
      if (ferr_set) frame_err <= 1'b1;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .wr     (push),
    .wdata  (shreg[7:0]),
    .rd     (rd),
    .q      (q),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed cases plus random frames
// compared against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int FLT   = 4;
  localparam int TMO   = 600;
  localparam int H     = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] q;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;
  logic       irq;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rd        (rd),
    .clr       (clr),
    .q         (q),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int irq_seen = 0;

  byte unsigned mq[$];
  bit m_ovf = 1'b0;
  bit m_ferr = 1'b0;
  int m_irq = 0;

  always @(posedge clk) if (irq === 1'b1) irq_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_q;
    exp_q = (mq.size() != 0) ? mq[0] : 8'h00;
    check($sformatf("%s.q", tag), q, exp_q);
    check($sformatf("%s.count", tag), count, mq.size());
    check($sformatf("%s.empty", tag), empty, mq.size() == 0);
    check($sformatf("%s.overflow", tag), overflow, m_ovf);
    check($sformatf("%s.frame_err", tag), frame_err, m_ferr);
    check($sformatf("%s.irqs", tag), irq_seen, m_irq);
  endtask

  // Drives an LSB-first frame; nbits < 11 truncates it. With rd_at_push, rd is
  // raised for exactly the cycle the byte is written (stop pin fall + 7 edges).
  task automatic send_frame(input byte unsigned data, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit rd_at_push);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = data;
    f[9]    = (~^data) ^ bad_par;
    f[10]   = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      tick(H);
      ps2c = 1'b0;
      if (rd_at_push && i == 10) begin
        tick(7);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        tick(H - 8);
      end else begin
        tick(H);
      end
      ps2c = 1'b1;
    end
    tick(H);
    ps2d = 1'b1;
    tick(4);
  endtask

  task automatic model_frame(input byte unsigned data, input bit bad_par, input bit bad_stop,
                             input bit rd_at_push);
    bit was_full;
    was_full = (mq.size() == DEPTH);
    if (rd_at_push && mq.size() != 0) void'(mq.pop_front());
    if (bad_stop || (PAR_CHK && bad_par)) begin
      m_ferr = 1'b1;
    end else if (was_full && !rd_at_push) begin
      m_ovf = 1'b1;
    end else begin
      mq.push_back(data);
      m_irq++;
    end
  endtask

  task automatic frame(input byte unsigned data, input bit bad_par, input bit bad_stop,
                       input bit rd_at_push);
    send_frame(data, bad_par, bad_stop, 11, rd_at_push);
    model_frame(data, bad_par, bad_stop, rd_at_push);
  endtask

  task automatic do_read();
    logic [7:0] exp_q;
    exp_q = (mq.size() != 0) ? mq[0] : 8'h00;
    check("rd.head", q, exp_q);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check("rd.count", count, mq.size());
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic drain();
    while (mq.size() != 0) do_read();
    check("drain.empty", empty, 1'b1);
  endtask

  initial begin
    nreset = 1'b0;
    tick(3);
    check_state("reset");
    check("reset.irq", irq, 1'b0);
    nreset = 1'b1;
    tick(4);

    frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_state("valid");
    do_read();
    check_state("valid_rd");

    frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check_state("bad_parity");
    do_clr();
    drain();

    frame(8'h2B, 1'b0, 1'b1, 1'b0);
    check_state("bad_stop");
    do_clr();

    for (int i = 1; i <= 9; i++) frame(byte'(i), 1'b0, 1'b0, 1'b0);
    check_state("overflow");
    do_clr();
    check_state("overflow_clr");
    frame(8'h0A, 1'b0, 1'b0, 1'b1);
    check_state("full_rd_push");
    drain();

    send_frame(8'h55, 1'b0, 1'b0, 4, 1'b0);
    tick(TMO + 200);
    m_ferr = 1'b1;
    check_state("timeout");
    do_clr();
    frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check_state("after_timeout");
    drain();

    ps2c = 1'b0;
    tick(2);
    ps2c = 1'b1;
    tick(30);
    check_state("glitch");
    frame(8'h33, 1'b0, 1'b0, 1'b0);
    check_state("after_glitch");
    drain();

    frame(8'h44, 1'b0, 1'b1, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, 5, 1'b0);
    nreset = 1'b0;
    tick(1);
    nreset = 1'b1;
    mq.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    tick(4);
    check_state("reset_mid");
    frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check_state("after_reset");

    for (int it = 0; it < 30; it++) begin
      byte unsigned d;
      bit bp, bs;
      int nrd;
      d   = byte'($urandom_range(0, 255));
      bp  = ($urandom_range(0, 5) == 0);
      bs  = ($urandom_range(0, 7) == 0);
      frame(d, bp, bs, 1'b0);
      check_state($sformatf("rand%0d", it));
      nrd = $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) do_read();
      if ($urandom_range(0, 4) == 0) do_clr();
    end
    check_state("rand_end");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
